// File: rtl/cache_line_filler.sv
// Miss-detect and line-fill controller for the single-line instruction cache.
// On a tag miss the whole line is streamed from ROM into the cache while the
// core is held. ROM data comes back ROM_LATENCY cycles after the address, so
// the write strobe and offset travel through a matching delay pipeline.
module cache_line_filler #(
  parameter int ADDR_W      = 8,
  parameter int OFFSET_W    = 5,
  parameter int ROM_LATENCY = 1   // legal 1..3
) (
  input  logic                       clk,
  input  logic                       reset,        // async, active low
  input  logic [ADDR_W-1:0]          pc,
  input  logic                       flush,
  output logic [ADDR_W-1:0]          rom_address,
  output logic [OFFSET_W-1:0]        cache_wroffset,
  output logic                       cache_wren,
  output logic [OFFSET_W-1:0]        cache_rdoffset,
  output logic                       hold_out,
  output logic                       line_valid,
  output logic [ADDR_W-OFFSET_W-1:0] line_tag,
  output logic [7:0]                 miss_count
);
  localparam int TAG_W = ADDR_W - OFFSET_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [OFFSET_W-1:0] FILL_LAST  = '1;
  localparam logic [1:0]          DRAIN_LAST = 2'(ROM_LATENCY - 1);

  logic [1:0]          state_q, state_d;
  logic [OFFSET_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [1:0]          drain_cnt_q, drain_cnt_d;
  logic                line_valid_q, line_valid_d;
  logic [TAG_W-1:0]    line_tag_q, line_tag_d;
  logic [7:0]          miss_count_q, miss_count_d;
  logic                flush_pending_q, flush_pending_d;

  // write pipeline: stage ROM_LATENCY-1 lines up with the returning ROM word
  logic [ROM_LATENCY-1:0]               vld_pipe_q, vld_pipe_d;
  logic [ROM_LATENCY-1:0][OFFSET_W-1:0] off_pipe_q, off_pipe_d;

  logic hit, miss, issue;

  assign hit   = line_valid_q && (pc[ADDR_W-1:OFFSET_W] == line_tag_q);
  assign miss  = ~hit;
  assign issue = (state_q == S_FILL);

  // next-state: tag capture on miss, fill/drain sequencing, flush tracking
  always_comb begin
    state_d         = state_q;
    fill_cnt_d      = fill_cnt_q;
    drain_cnt_d     = drain_cnt_q;
    line_valid_d    = line_valid_q;
    line_tag_d      = line_tag_q;
    miss_count_d    = miss_count_q;
    flush_pending_d = flush_pending_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          line_tag_d      = pc[ADDR_W-1:OFFSET_W];
          line_valid_d    = 1'b0;
          fill_cnt_d      = '0;
          flush_pending_d = 1'b0;
          if (miss_count_q != 8'hFF) miss_count_d = miss_count_q + 8'd1;
          state_d         = S_FILL;
        end else if (flush) begin
          // invalidate now; the resulting miss shows up next cycle
          line_valid_d = 1'b0;
        end
      end
      S_FILL: begin
        if (flush) flush_pending_d = 1'b1;
        fill_cnt_d = fill_cnt_q + 1'b1;   // wraps to 0 after the last word
        if (fill_cnt_q == FILL_LAST) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        if (flush) flush_pending_d = 1'b1;
        if (drain_cnt_q == DRAIN_LAST) begin
          // a flush that lands on the final drain cycle still counts
          line_valid_d    = ~(flush_pending_q | flush);
          flush_pending_d = 1'b0;
          state_d         = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // write pipeline shift: issue strobe and fill offset delayed ROM_LATENCY cycles
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    off_pipe_d    = off_pipe_q;
    vld_pipe_d[0] = issue;
    off_pipe_d[0] = fill_cnt_q;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      off_pipe_d[i] = off_pipe_q[i-1];
    end
  end

  // state registers; reset also drops any in-flight writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      fill_cnt_q      <= '0;
      drain_cnt_q     <= '0;
      line_valid_q    <= 1'b0;
      line_tag_q      <= '0;
      miss_count_q    <= '0;
      flush_pending_q <= 1'b0;
      vld_pipe_q      <= '0;
      off_pipe_q      <= '0;
    end else begin
      state_q         <= state_d;
      fill_cnt_q      <= fill_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      line_valid_q    <= line_valid_d;
      line_tag_q      <= line_tag_d;
      miss_count_q    <= miss_count_d;
      flush_pending_q <= flush_pending_d;
      vld_pipe_q      <= vld_pipe_d;
      off_pipe_q      <= off_pipe_d;
    end
  end

  // ROM address and core hold; IDLE passes pc through so a hit costs nothing
  always_comb begin
    rom_address = pc;
    hold_out    = 1'b1;
    case (state_q)
      S_IDLE:  hold_out    = miss;
      S_FILL:  rom_address = {line_tag_q, fill_cnt_q};
      S_DRAIN: rom_address = {line_tag_q, {OFFSET_W{1'b0}}};
      default: hold_out    = 1'b1;
    endcase
  end

  assign cache_wren     = vld_pipe_q[ROM_LATENCY-1];
  assign cache_wroffset = off_pipe_q[ROM_LATENCY-1];
  assign cache_rdoffset = pc[OFFSET_W-1:0];
  assign line_valid     = line_valid_q;
  assign line_tag       = line_tag_q;
  assign miss_count     = miss_count_q;
endmodule

// File: tb/tb_cache_line_filler.sv
// Directed bench for cache_line_filler. Two instances (ROM_LATENCY 1 and 3)
// share the clock; sel picks which one the scenario tasks drive and observe.
module tb_cache_line_filler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v, flush_v;
  logic [7:0] pc_v [2];

  logic [7:0] rom1, rom3, mc1, mc3;
  logic [4:0] wroff1, wroff3, rdoff1, rdoff3;
  logic       wren1, wren3, hold1, hold3, lv1, lv3;
  logic [2:0] tag1, tag3;

  cache_line_filler #(.ADDR_W(8), .OFFSET_W(5), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst_v[0]), .pc(pc_v[0]), .flush(flush_v[0]),
    .rom_address(rom1), .cache_wroffset(wroff1), .cache_wren(wren1),
    .cache_rdoffset(rdoff1), .hold_out(hold1), .line_valid(lv1),
    .line_tag(tag1), .miss_count(mc1));

  cache_line_filler #(.ADDR_W(8), .OFFSET_W(5), .ROM_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst_v[1]), .pc(pc_v[1]), .flush(flush_v[1]),
    .rom_address(rom3), .cache_wroffset(wroff3), .cache_wren(wren3),
    .cache_rdoffset(rdoff3), .hold_out(hold3), .line_valid(lv3),
    .line_tag(tag3), .miss_count(mc3));

  int sel = 0;
  int lat = 1;
  int checks = 0;
  int errors = 0;

  logic [7:0] rom, mc;
  logic [4:0] wroff, rdoff;
  logic       wren, hold, lv;
  logic [2:0] tag;

  always_comb begin
    if (sel == 0) begin
      rom = rom1; mc = mc1; wroff = wroff1; rdoff = rdoff1;
      wren = wren1; hold = hold1; lv = lv1; tag = tag1;
    end else begin
      rom = rom3; mc = mc3; wroff = wroff3; rdoff = rdoff3;
      wren = wren3; hold = hold3; lv = lv3; tag = tag3;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Observes one complete miss sequence starting at the IDLE miss cycle (i=0).
  // FILL cycle j is i=j+1; write of word j is expected at i=j+1+lat.
  task automatic run_fill(input logic [7:0] base, input int sw_i, input logic [7:0] sw_pc,
                          input int fl_i, input logic end_hold);
    logic exp_w;
    for (int i = 0; i <= 33 + lat; i++) begin
      if (i == sw_i) pc_v[sel] = sw_pc;
      flush_v[sel] = (i == fl_i);
      #1;
      checks++;
      if (hold !== ((i <= 32 + lat) ? 1'b1 : end_hold)) begin
        errors++;
        $display("FAIL fill_hold L=%0d i=%0d: got %b want %b", lat, i, hold,
                 (i <= 32 + lat) ? 1'b1 : end_hold);
      end
      if (i >= 1 && i <= 32) begin
        checks++;
        if (rom !== base + 8'(i - 1)) begin
          errors++;
          $display("FAIL fill_rom L=%0d i=%0d: got %h want %h", lat, i, rom, base + 8'(i - 1));
        end
      end
      if (i >= 33 && i <= 32 + lat) begin
        checks++;
        if (rom !== base) begin
          errors++;
          $display("FAIL drain_rom L=%0d i=%0d: got %h want %h", lat, i, rom, base);
        end
      end
      exp_w = (i >= 1 + lat) && (i <= 32 + lat);
      checks++;
      if (wren !== exp_w) begin
        errors++;
        $display("FAIL fill_wren L=%0d i=%0d: got %b want %b", lat, i, wren, exp_w);
      end
      if (exp_w) begin
        checks++;
        if (wroff !== 5'(i - 1 - lat)) begin
          errors++;
          $display("FAIL fill_wroff L=%0d i=%0d: got %0d want %0d", lat, i, wroff, i - 1 - lat);
        end
      end
      checks++;
      if (rdoff !== pc_v[sel][4:0]) begin
        errors++;
        $display("FAIL rdoffset L=%0d i=%0d: got %h want %h", lat, i, rdoff, pc_v[sel][4:0]);
      end
      if (i < 33 + lat) tick;
    end
    flush_v[sel] = 1'b0;
  endtask

  task automatic test_reset;
    pc_v[sel] = 8'h00;
    flush_v[sel] = 1'b0;
    rst_v[sel] = 1'b0;
    tick; tick;
    checks++;
    if ({hold, lv, tag, mc, wren, wroff} !== {1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL reset_state L=%0d: got hold=%b lv=%b tag=%0d mc=%0d wren=%b wroff=%0d want 1 0 0 0 0 0",
               lat, hold, lv, tag, mc, wren, wroff);
    end
    checks++;
    if (rom !== 8'h00) begin
      errors++;
      $display("FAIL reset_rom L=%0d: got %h want 00", lat, rom);
    end
    rst_v[sel] = 1'b1;
    run_fill(8'h00, -1, 8'h00, -1, 1'b0);
    checks++;
    if ({lv, tag, mc} !== {1'b1, 3'd0, 8'd1}) begin
      errors++;
      $display("FAIL first_fill_result L=%0d: got lv=%b tag=%0d mc=%0d want 1 0 1", lat, lv, tag, mc);
    end
  endtask

  task automatic test_hit_stream;
    for (int a = 5; a <= 31; a++) begin
      pc_v[sel] = 8'(a);
      #1;
      checks++;
      if ({hold, wren} !== 2'b00 || rdoff !== 5'(a)) begin
        errors++;
        $display("FAIL hit_stream L=%0d pc=%h: got hold=%b wren=%b rdoff=%h want 0 0 %h",
                 lat, a, hold, wren, rdoff, 5'(a));
      end
      tick;
    end
    checks++;
    if (mc !== 8'd1) begin
      errors++;
      $display("FAIL hit_miss_count L=%0d: got %0d want 1", lat, mc);
    end
  endtask

  task automatic test_refill;
    pc_v[sel] = 8'h47;
    run_fill(8'h40, -1, 8'h00, -1, 1'b0);
    checks++;
    if ({lv, tag, mc} !== {1'b1, 3'd2, 8'd2}) begin
      errors++;
      $display("FAIL refill_47 L=%0d: got lv=%b tag=%0d mc=%0d want 1 2 2", lat, lv, tag, mc);
    end
    pc_v[sel] = 8'h05;
    run_fill(8'h00, -1, 8'h00, -1, 1'b0);
    checks++;
    if ({lv, tag, mc} !== {1'b1, 3'd0, 8'd3}) begin
      errors++;
      $display("FAIL refill_05 L=%0d: got lv=%b tag=%0d mc=%0d want 1 0 3", lat, lv, tag, mc);
    end
  endtask

  // pc moves to another tag mid-fill: the fill ignores it, then IDLE misses at once
  task automatic test_back_to_back;
    pc_v[sel] = 8'h25;
    run_fill(8'h20, 5, 8'h85, -1, 1'b1);
    checks++;
    if (tag !== 3'd1) begin
      errors++;
      $display("FAIL b2b_first_tag L=%0d: got %0d want 1", lat, tag);
    end
    run_fill(8'h80, -1, 8'h00, -1, 1'b0);
    checks++;
    if ({lv, tag, mc} !== {1'b1, 3'd4, 8'd5}) begin
      errors++;
      $display("FAIL b2b_second L=%0d: got lv=%b tag=%0d mc=%0d want 1 4 5", lat, lv, tag, mc);
    end
  endtask

  // flush pulse at FILL cycle 10: line ends invalid and the same pc refills
  task automatic test_flush;
    pc_v[sel] = 8'h65;
    run_fill(8'h60, -1, 8'h00, 11, 1'b1);
    checks++;
    if (lv !== 1'b0) begin
      errors++;
      $display("FAIL flush_invalid L=%0d: got %b want 0", lat, lv);
    end
    run_fill(8'h60, -1, 8'h00, -1, 1'b0);
    checks++;
    if ({lv, tag, mc} !== {1'b1, 3'd3, 8'd7}) begin
      errors++;
      $display("FAIL flush_refill L=%0d: got lv=%b tag=%0d mc=%0d want 1 3 7", lat, lv, tag, mc);
    end
  endtask

  // reset dropped for one cycle at FILL cycle 20
  task automatic test_reset_midfill;
    pc_v[sel] = 8'hA3;
    #1;
    checks++;
    if (hold !== 1'b1) begin
      errors++;
      $display("FAIL midreset_miss L=%0d: got %b want 1", lat, hold);
    end
    repeat (21) tick;
    checks++;
    if (wren !== 1'b1) begin
      errors++;
      $display("FAIL midreset_prewren L=%0d: got %b want 1", lat, wren);
    end
    rst_v[sel] = 1'b0;
    #1;
    checks++;
    if ({hold, lv, tag, mc, wren, wroff, rom} !== {1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'd0, 8'hA3}) begin
      errors++;
      $display("FAIL midreset_state L=%0d: got hold=%b lv=%b tag=%0d mc=%0d wren=%b wroff=%0d rom=%h want 1 0 0 0 0 0 a3",
               lat, hold, lv, tag, mc, wren, wroff, rom);
    end
    tick;
    checks++;
    if (wren !== 1'b0) begin
      errors++;
      $display("FAIL midreset_wren L=%0d: got %b want 0", lat, wren);
    end
    rst_v[sel] = 1'b1;
    run_fill(8'hA0, -1, 8'h00, -1, 1'b0);
    checks++;
    if ({lv, tag, mc} !== {1'b1, 3'd5, 8'd1}) begin
      errors++;
      $display("FAIL midreset_refill L=%0d: got lv=%b tag=%0d mc=%0d want 1 5 1", lat, lv, tag, mc);
    end
  endtask

  task automatic test_saturate;
    int budget;
    rst_v[sel] = 1'b0;
    tick;
    rst_v[sel] = 1'b1;
    for (int n = 1; n <= 260; n++) begin
      pc_v[sel] = n[0] ? 8'h20 : 8'h00;
      #1;
      checks++;
      if (hold !== 1'b1) begin
        errors++;
        $display("FAIL sat_miss n=%0d: got %b want 1", n, hold);
      end
      budget = 0;
      tick;
      while (hold !== 1'b0 && budget < 60) begin
        tick;
        budget++;
      end
      if (budget >= 60) begin
        errors++;
        $display("FAIL sat_timeout n=%0d: hold still %b after 60 cycles", n, hold);
      end
      if (n == 100 || n == 255 || n == 260) begin
        checks++;
        if (mc !== ((n == 100) ? 8'd100 : 8'd255)) begin
          errors++;
          $display("FAIL sat_count n=%0d: got %0d want %0d", n, mc, (n == 100) ? 100 : 255);
        end
      end
    end
  endtask

  initial begin
    rst_v = 2'b00;
    flush_v = 2'b00;
    pc_v[0] = 8'h00;
    pc_v[1] = 8'h00;
    repeat (2) tick;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      lat = (s == 0) ? 1 : 3;
      test_reset;
      test_hit_stream;
      test_refill;
      test_back_to_back;
      test_flush;
      test_reset_midfill;
    end
    sel = 0;
    lat = 1;
    test_saturate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
